// File: rtl/jogo_pkg.sv
// Shared types, widths and arithmetic helpers for the per-frame collision/scoring stage.
package jogo_pkg;

   localparam int COORD_W = 10;
   localparam int DIST_W  = 22;
   localparam logic [6:0] HEX_BLANK = 7'h7F;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [DIST_W-1:0]  dist_t;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      AMOSTRA      = 3'd1,
      TESTA_ALIADA = 3'd2,
      TESTA_NAVE   = 3'd3,
      ATUALIZA     = 3'd4,
      FIM          = 3'd5
   } estado_t;

   // |a-b| on 11-bit operands; magnitude of a signed difference without sign handling.
   function automatic logic [10:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
      if (a >= b) begin
         return a - b;
      end else begin
         return b - a;
      end
   endfunction

   function automatic dist_t sq(input logic [10:0] v);
      dist_t w;
      w = {11'd0, v};
      return w * w;
   endfunction

   // Adds pts to a 4-digit BCD value; any carry out of the thousands digit saturates at 9999.
   function automatic logic [15:0] bcd_add_sat(input logic [15:0] p, input logic [3:0] pts);
      logic [15:0] r;
      logic [4:0]  d;
      logic [3:0]  c;
      r = 16'h0000;
      c = pts;
      for (int i = 0; i < 4; i++) begin
         d = {1'b0, p[4*i +: 4]} + {1'b0, c};
         if (d > 5'd9) begin
            d = d - 5'd10;
            r[4*i +: 4] = d[3:0];
            c = 4'd1;
         end else begin
            r[4*i +: 4] = d[3:0];
            c = 4'd0;
         end
      end
      if (c != 4'd0) begin
         r = 16'h9999;
      end else begin
         r = r;
      end
      return r;
   endfunction

endpackage

// File: rtl/collision_score_if.sv
// Position bus from the entity stage plus the hit pulses returned to it.
interface collision_score_if;
   import jogo_pkg::*;

   logic   frame_tick;
   logic   pausa;
   coord_t x_bola_aliada;
   coord_t y_bola_aliada;
   coord_t raio_bola_aliada;
   coord_t x_bola_inimiga;
   coord_t y_bola_inimiga;
   coord_t raio_bola_inimiga;
   coord_t x_nave;
   coord_t y_nave;
   coord_t largura_nave;
   coord_t altura_nave;
   logic   acerto_inimigo;
   logic   nave_atingida;

   modport master (
      output frame_tick, pausa,
      output x_bola_aliada, y_bola_aliada, raio_bola_aliada,
      output x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga,
      output x_nave, y_nave, largura_nave, altura_nave,
      input  acerto_inimigo, nave_atingida
   );

   modport slave (
      input  frame_tick, pausa,
      input  x_bola_aliada, y_bola_aliada, raio_bola_aliada,
      input  x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga,
      input  x_nave, y_nave, largura_nave, altura_nave,
      output acerto_inimigo, nave_atingida
   );
endinterface

// File: rtl/hex7seg.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes are blanked.
module hex7seg
   import jogo_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Segment lookup
   always_comb begin
      seg = HEX_BLANK;
      case (bcd)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = HEX_BLANK;
      endcase
   end

endmodule

// File: rtl/collision_score.sv
// Per-frame collision/scoring stage: samples positions once per frame, runs the ally/enemy
// and enemy/nave overlap tests, and keeps the BCD score, life count and game-over flag.
module collision_score
   import jogo_pkg::*;
#(
   parameter int VIDAS_INICIAIS = 3,
   parameter int PONTOS_ACERTO  = 1,
   parameter int INVULN_FRAMES  = 60
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   collision_score_if.slave    bus,
   output logic                perdeu,
   output logic [15:0]         placar,
   output logic [3:0]          vidas,
   output logic [6:0]          HEX0,
   output logic [6:0]          HEX1,
   output logic [6:0]          HEX2,
   output logic [6:0]          HEX3,
   output logic [6:0]          HEX4,
   output logic [6:0]          HEX5
);

   estado_t     estado_r;
   coord_t      xa_r, ya_r, ra_r, xi_r, yi_r, ri_r, xn_r, yn_r, wn_r, hn_r;
   logic        hit_a_r, hit_n_r;
   logic        acerto_r, atingida_r, perdeu_r;
   logic [15:0] placar_r;
   logic [3:0]  vidas_r;
   logic [15:0] invuln_r;

   logic [10:0] dxa_s, dya_s, rsum_s;
   dist_t       dist_a_s, lim_a_s, dist_n_s, lim_n_s;
   logic [10:0] xi_e_s, yi_e_s, x_fim_s, y_fim_s, cx_s, cy_s, dxn_s, dyn_s;
   logic        hit_a_s, hit_n_s;

   assign dxa_s    = abs_diff({1'b0, xa_r}, {1'b0, xi_r});
   assign dya_s    = abs_diff({1'b0, ya_r}, {1'b0, yi_r});
   assign rsum_s   = {1'b0, ra_r} + {1'b0, ri_r};
   assign dist_a_s = sq(dxa_s) + sq(dya_s);
   assign lim_a_s  = sq(rsum_s);

   assign xi_e_s   = {1'b0, xi_r};
   assign yi_e_s   = {1'b0, yi_r};
   assign x_fim_s  = {1'b0, xn_r} + {1'b0, wn_r} - 11'd1;
   assign y_fim_s  = {1'b0, yn_r} + {1'b0, hn_r} - 11'd1;

   // Closest point of the nave rectangle to the enemy centre
   always_comb begin
      cx_s = xi_e_s;
      cy_s = yi_e_s;
      if (xi_e_s < {1'b0, xn_r}) begin
         cx_s = {1'b0, xn_r};
      end else if (xi_e_s > x_fim_s) begin
         cx_s = x_fim_s;
      end else begin
         cx_s = xi_e_s;
      end
      if (yi_e_s < {1'b0, yn_r}) begin
         cy_s = {1'b0, yn_r};
      end else if (yi_e_s > y_fim_s) begin
         cy_s = y_fim_s;
      end else begin
         cy_s = yi_e_s;
      end
   end

   assign dxn_s    = abs_diff(xi_e_s, cx_s);
   assign dyn_s    = abs_diff(yi_e_s, cy_s);
   assign dist_n_s = sq(dxn_s) + sq(dyn_s);
   assign lim_n_s  = sq({1'b0, ri_r});

   // Overlap decisions, suppressed for inactive balls and during invulnerability
   always_comb begin
      hit_a_s = 1'b0;
      hit_n_s = 1'b0;
      if ((ra_r != 10'd0) && (ri_r != 10'd0)) begin
         hit_a_s = (dist_a_s <= lim_a_s);
      end else begin
         hit_a_s = 1'b0;
      end
      if ((ri_r != 10'd0) && (invuln_r == 16'd0)) begin
         hit_n_s = (dist_n_s <= lim_n_s);
      end else begin
         hit_n_s = 1'b0;
      end
   end

   // Frame sequencer with registered pulses, score, lives and invulnerability
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         estado_r   <= IDLE;
         {xa_r, ya_r, ra_r, xi_r, yi_r} <= {5{10'd0}};
         {ri_r, xn_r, yn_r, wn_r, hn_r} <= {5{10'd0}};
         hit_a_r    <= 1'b0;
         hit_n_r    <= 1'b0;
         acerto_r   <= 1'b0;
         atingida_r <= 1'b0;
         perdeu_r   <= 1'b0;
         placar_r   <= 16'h0000;
         vidas_r    <= 4'(VIDAS_INICIAIS);
         invuln_r   <= 16'd0;
      end else begin
         acerto_r   <= 1'b0;
         atingida_r <= 1'b0;
         case (estado_r)
            IDLE: begin
               if (bus.frame_tick && !bus.pausa && !perdeu_r) begin
                  estado_r <= AMOSTRA;
               end else begin
                  estado_r <= IDLE;
               end
            end
            AMOSTRA: begin
               xa_r <= bus.x_bola_aliada;
               ya_r <= bus.y_bola_aliada;
               ra_r <= bus.raio_bola_aliada;
               xi_r <= bus.x_bola_inimiga;
               yi_r <= bus.y_bola_inimiga;
               ri_r <= bus.raio_bola_inimiga;
               xn_r <= bus.x_nave;
               yn_r <= bus.y_nave;
               wn_r <= bus.largura_nave;
               hn_r <= bus.altura_nave;
               estado_r <= TESTA_ALIADA;
            end
            TESTA_ALIADA: begin
               hit_a_r  <= hit_a_s;
               estado_r <= TESTA_NAVE;
            end
            TESTA_NAVE: begin
               hit_n_r  <= hit_n_s;
               estado_r <= ATUALIZA;
            end
            ATUALIZA: begin
               if (hit_a_r) begin
                  placar_r <= bcd_add_sat(placar_r, 4'(PONTOS_ACERTO));
                  acerto_r <= 1'b1;
               end else begin
                  placar_r <= placar_r;
               end
               if (hit_n_r) begin
                  vidas_r    <= vidas_r - 4'd1;
                  atingida_r <= 1'b1;
                  invuln_r   <= 16'(INVULN_FRAMES);
                  if (vidas_r == 4'd1) begin
                     perdeu_r <= 1'b1;
                     estado_r <= FIM;
                  end else begin
                     estado_r <= IDLE;
                  end
               end else begin
                  if (invuln_r != 16'd0) begin
                     invuln_r <= invuln_r - 16'd1;
                  end else begin
                     invuln_r <= invuln_r;
                  end
                  estado_r <= IDLE;
               end
            end
            FIM: begin
               estado_r <= FIM;
            end
            default: begin
               estado_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.acerto_inimigo = acerto_r;
   assign bus.nave_atingida  = atingida_r;
   assign perdeu             = perdeu_r;
   assign placar             = placar_r;
   assign vidas              = vidas_r;
   assign HEX4               = HEX_BLANK;

   hex7seg u_hex0 (.bcd(placar_r[3:0]),   .seg(HEX0));
   hex7seg u_hex1 (.bcd(placar_r[7:4]),   .seg(HEX1));
   hex7seg u_hex2 (.bcd(placar_r[11:8]),  .seg(HEX2));
   hex7seg u_hex3 (.bcd(placar_r[15:12]), .seg(HEX3));
   hex7seg u_hex5 (.bcd(vidas_r),         .seg(HEX5));

endmodule

// File: tb/tb_collision_score.sv
// Directed bench for collision_score: a default-parameter instance for gameplay cases and a
// 9-points-per-hit instance to reach score saturation quickly.
module tb_collision_score;
   import jogo_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   collision_score_if bus ();
   collision_score_if bus9 ();

   logic        perdeu, perdeu9;
   logic [15:0] placar, placar9;
   logic [3:0]  vidas, vidas9;
   logic [6:0]  h0, h1, h2, h3, h4, h5;
   logic [6:0]  g0, g1, g2, g3, g4, g5;

   collision_score dut (
      .CLOCK_50(clk), .reset(reset), .bus(bus), .perdeu(perdeu), .placar(placar),
      .vidas(vidas), .HEX0(h0), .HEX1(h1), .HEX2(h2), .HEX3(h3), .HEX4(h4), .HEX5(h5)
   );

   collision_score #(.VIDAS_INICIAIS(3), .PONTOS_ACERTO(9), .INVULN_FRAMES(0)) dut9 (
      .CLOCK_50(clk), .reset(reset), .bus(bus9), .perdeu(perdeu9), .placar(placar9),
      .vidas(vidas9), .HEX0(g0), .HEX1(g1), .HEX2(g2), .HEX3(g3), .HEX4(g4), .HEX5(g5)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_pos(input int xa, ya, ra, xi, yi, ri, xn, yn, wn, hn);
      bus.x_bola_aliada     = 10'(xa);
      bus.y_bola_aliada     = 10'(ya);
      bus.raio_bola_aliada  = 10'(ra);
      bus.x_bola_inimiga    = 10'(xi);
      bus.y_bola_inimiga    = 10'(yi);
      bus.raio_bola_inimiga = 10'(ri);
      bus.x_nave            = 10'(xn);
      bus.y_nave            = 10'(yn);
      bus.largura_nave      = 10'(wn);
      bus.altura_nave       = 10'(hn);
   endtask

   // One frame on the main DUT: pulses must be quiet until T+4, match there, then drop.
   task automatic run_frame(input string tag, input logic ea, input logic en);
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
      repeat (3) @(negedge clk);
      chk({tag, "_early"}, {30'd0, bus.acerto_inimigo, bus.nave_atingida}, 32'd0);
      @(negedge clk);
      chk({tag, "_pulse"}, {30'd0, bus.acerto_inimigo, bus.nave_atingida}, {30'd0, ea, en});
      @(negedge clk);
      chk({tag, "_drop"}, {30'd0, bus.acerto_inimigo, bus.nave_atingida}, 32'd0);
   endtask

   task automatic run_frame9(output logic pulse);
      bus9.frame_tick = 1'b1;
      @(negedge clk);
      bus9.frame_tick = 1'b0;
      repeat (4) @(negedge clk);
      pulse = bus9.acerto_inimigo;
      @(negedge clk);
   endtask

   initial begin
      logic p9;
      reset = 1'b1;
      bus.frame_tick = 1'b0;
      bus.pausa = 1'b0;
      bus9.frame_tick = 1'b0;
      bus9.pausa = 1'b0;
      set_pos(100, 100, 5, 108, 100, 3, 500, 400, 20, 10);
      bus9.x_bola_aliada = 10'd100;  bus9.y_bola_aliada = 10'd100;  bus9.raio_bola_aliada = 10'd5;
      bus9.x_bola_inimiga = 10'd108; bus9.y_bola_inimiga = 10'd100; bus9.raio_bola_inimiga = 10'd3;
      bus9.x_nave = 10'd500; bus9.y_nave = 10'd400; bus9.largura_nave = 10'd20; bus9.altura_nave = 10'd10;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // 1: reset state
      chk("rst_placar", placar, 32'h0000);
      chk("rst_vidas", vidas, 32'd3);
      chk("rst_perdeu", perdeu, 32'd0);
      chk("rst_hex0", h0, 32'h40);
      chk("rst_hex3", h3, 32'h40);
      chk("rst_hex4", h4, 32'h7F);
      chk("rst_hex5", h5, 32'h30);

      // 2: ally hits enemy exactly at touching distance, then one pixel further misses
      run_frame("t2_hit", 1'b1, 1'b0);
      chk("t2_placar", placar, 32'h0001);
      chk("t2_hex0", h0, 32'h79);
      set_pos(100, 100, 5, 109, 100, 3, 500, 400, 20, 10);
      run_frame("t2_miss", 1'b0, 1'b0);
      chk("t2_placar_miss", placar, 32'h0001);

      // 5b: paused ticks are dropped even with an overlap present
      set_pos(100, 100, 5, 108, 100, 3, 500, 400, 20, 10);
      bus.pausa = 1'b1;
      for (int i = 0; i < 10; i++) run_frame("t5_pausa", 1'b0, 1'b0);
      chk("t5_pausa_placar", placar, 32'h0001);
      bus.pausa = 1'b0;

      // 3: enemy touches nave edge, then 60 invulnerable frames, then another life lost
      set_pos(0, 0, 0, 50, 50, 4, 40, 54, 20, 10);
      run_frame("t3_hit", 1'b0, 1'b1);
      chk("t3_vidas", vidas, 32'd2);
      chk("t3_hex5", h5, 32'h24);
      for (int i = 0; i < 60; i++) run_frame("t3_inv", 1'b0, 1'b0);
      chk("t3_vidas_inv", vidas, 32'd2);
      run_frame("t3_hit61", 1'b0, 1'b1);
      chk("t3_vidas61", vidas, 32'd1);
      for (int i = 0; i < 60; i++) run_frame("t4_inv", 1'b0, 1'b0);

      // 4: both overlaps in the last-life frame
      set_pos(50, 50, 1, 50, 50, 4, 40, 54, 20, 10);
      run_frame("t4_both", 1'b1, 1'b1);
      chk("t4_placar", placar, 32'h0002);
      chk("t4_vidas", vidas, 32'd0);
      chk("t4_perdeu", perdeu, 32'd1);
      for (int i = 0; i < 3; i++) run_frame("t4_fim", 1'b0, 1'b0);
      chk("t4_placar_fim", placar, 32'h0002);
      chk("t4_perdeu_fim", perdeu, 32'd1);

      // 6: reset while TESTA_NAVE is in progress
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      set_pos(100, 100, 5, 108, 100, 3, 500, 400, 20, 10);
      run_frame("t6_pre", 1'b1, 1'b0);
      chk("t6_pre_placar", placar, 32'h0001);
      set_pos(0, 0, 0, 50, 50, 4, 40, 54, 20, 10);
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("t6_placar", placar, 32'h0000);
      chk("t6_vidas", vidas, 32'd3);
      chk("t6_perdeu", perdeu, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t6_pulse_rst", {30'd0, bus.acerto_inimigo, bus.nave_atingida}, 32'd0);
      end
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t6_pulse_after", {30'd0, bus.acerto_inimigo, bus.nave_atingida}, 32'd0);
      end
      chk("t6_hex5", h5, 32'h30);

      // 5a: BCD carries and saturation at 9999 (9 points per hit)
      run_frame9(p9);
      chk("t5_first9", placar9, 32'h0009);
      run_frame9(p9);
      chk("t5_carry", placar9, 32'h0018);
      for (int i = 2; i < 1111; i++) run_frame9(p9);
      chk("t5_9999", placar9, 32'h9999);
      chk("t5_hex3", g3, 32'h10);
      run_frame9(p9);
      chk("t5_sat_pulse", p9, 32'd1);
      chk("t5_sat", placar9, 32'h9999);
      chk("t5_vidas9", vidas9, 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
